// File: rtl/apb_master_bridge.sv
// apb_master_bridge: command/response handshake to APB initiator, one transfer at a time.
// Optional ACCESS-phase timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_bridge #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PWRITE,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
    state_t state;
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range 1..255");
    end
`ifdef APB_MASTER_TIMEOUT_EN
    logic [7:0] tcnt;
    localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);
`else
    assign rsp_err = 1'b0;
`endif
    // cmd_ready is registered so it stays low while reset is held
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
            rsp_err   <= 1'b0;
            tcnt      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready <= !(cmd_valid && cmd_ready);
                    if (cmd_valid && cmd_ready) begin
                        state  <= SETUP;
                        PSEL   <= 1'b1;
                        PADDR  <= cmd_addr;
                        PWRITE <= cmd_write;
                        PWDATA <= cmd_wdata;
`ifdef APB_MASTER_TIMEOUT_EN
                        tcnt   <= '0;
`endif
                    end
                end
                SETUP: begin
                    state   <= ACCESS;
                    PENABLE <= 1'b1;
                end
                ACCESS: begin
                    if (PREADY) begin
                        state     <= RESP;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= PWRITE ? '0 : PRDATA;
`ifdef APB_MASTER_TIMEOUT_EN
                        rsp_err   <= 1'b0;
                    end else if (tcnt == LAST) begin
                        state     <= RESP;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                    end else begin
                        tcnt      <= tcnt + 8'd1;
`endif
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed vectors for apb_master_bridge, cycle-exact checks.
module tb_apb_master_bridge;
    logic       PCLK = 1'b0;
    logic       PRESET;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [7:0] cmd_addr, cmd_wdata;
    logic       rsp_valid, rsp_ready, rsp_err;
    logic [7:0] rsp_rdata;
    logic [7:0] PADDR, PWDATA, PRDATA;
    logic       PWRITE, PSEL, PENABLE, PREADY;
    int n_checks = 0;
    int n_errors = 0;

    apb_master_bridge #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .TIMEOUT_CYCLES(4)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge PCLK);
        #1;
    endtask

    task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] d);
        check("issue_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        step;
        cmd_valid = 1'b0;
    endtask

    initial begin
        PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b1; PRDATA = '0; PREADY = 1'b0;
        #2;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_psel", PSEL, 0);
        check("rst_penable", PENABLE, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_paddr", PADDR, 0);
        step;
        check("rst_ready_hold", cmd_ready, 0);
        PRESET = 1'b0;
        step;
        check("rel_ready", cmd_ready, 1);

        // write, zero wait states
        PREADY = 1'b1;
        issue(1'b1, 8'h08, 8'h5A);
        check("wr_setup_psel", PSEL, 1);
        check("wr_setup_pen", PENABLE, 0);
        check("wr_paddr", PADDR, 8'h08);
        check("wr_pwdata", PWDATA, 8'h5A);
        check("wr_pwrite", PWRITE, 1);
        check("wr_busy", cmd_ready, 0);
        step;
        check("wr_acc_psel", PSEL, 1);
        check("wr_acc_pen", PENABLE, 1);
        check("wr_acc_nrsp", rsp_valid, 0);
        step;
        check("wr_rsp_valid", rsp_valid, 1);
        check("wr_rsp_err", rsp_err, 0);
        check("wr_rsp_rdata", rsp_rdata, 0);
        check("wr_rsp_psel", PSEL, 0);
        step;
        check("wr_done_valid", rsp_valid, 0);
        check("wr_done_ready", cmd_ready, 1);

        // read with 3 wait states
        PREADY = 1'b0; PRDATA = 8'hFF;
        issue(1'b0, 8'h10, 8'h00);
        step;
        check("rd_acc_pen", PENABLE, 1);
        for (int i = 0; i < 3; i++) begin
            step;
            check("rd_wait_pen", PENABLE, 1);
            check("rd_wait_nrsp", rsp_valid, 0);
        end
        PREADY = 1'b1; PRDATA = 8'hC3;
        step;
        check("rd_rsp_valid", rsp_valid, 1);
        check("rd_rsp_rdata", rsp_rdata, 8'hC3);
        check("rd_rsp_psel", PSEL, 0);
        PRDATA = 8'h99;
        step;
        check("rd_done_ready", cmd_ready, 1);
        check("rd_hold_rdata", rsp_rdata, 8'hC3);

        // response backpressure with a pending command
        rsp_ready = 1'b0; PRDATA = 8'h7E;
        issue(1'b0, 8'h20, 8'h00);
        step;
        step;
        PRDATA = 8'h00;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h33; cmd_wdata = 8'h11;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", rsp_valid, 1);
            check("bp_rdata", rsp_rdata, 8'h7E);
            check("bp_ready", cmd_ready, 0);
            check("bp_psel", PSEL, 0);
            step;
        end
        rsp_ready = 1'b1;
        step;
        check("bp_idle_valid", rsp_valid, 0);
        check("bp_idle_ready", cmd_ready, 1);
        step;
        cmd_valid = 1'b0;
        check("pend_psel", PSEL, 1);
        check("pend_paddr", PADDR, 8'h33);
        check("pend_pwdata", PWDATA, 8'h11);
        check("pend_pwrite", PWRITE, 1);
        step;
        step;
        check("pend_rsp", rsp_valid, 1);
        step;

        // stalled ACCESS: timeout when enabled, indefinite wait otherwise
        PREADY = 1'b0; PRDATA = 8'hAA;
        issue(1'b0, 8'h44, 8'h00);
        step;
`ifdef APB_MASTER_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            step;
            check("to_wait_psel", PSEL, 1);
        end
        step;
        check("to_psel", PSEL, 0);
        check("to_pen", PENABLE, 0);
        check("to_valid", rsp_valid, 1);
        check("to_err", rsp_err, 1);
        check("to_rdata", rsp_rdata, 0);
        step;
        issue(1'b0, 8'h45, 8'h00);
        step;
        step;
        step;
        step;
        PREADY = 1'b1; PRDATA = 8'h5C;
        step;
        check("edge_valid", rsp_valid, 1);
        check("edge_err", rsp_err, 0);
        check("edge_rdata", rsp_rdata, 8'h5C);
        step;
`else
        for (int i = 0; i < 100; i++) begin
            step;
            check("nto_access", {29'd0, PSEL, PENABLE, rsp_valid}, 3'b110);
        end
        PREADY = 1'b1; PRDATA = 8'h5C;
        step;
        check("nto_valid", rsp_valid, 1);
        check("nto_err", rsp_err, 0);
        check("nto_rdata", rsp_rdata, 8'h5C);
        step;
`endif

        // asynchronous reset in the middle of ACCESS
        PREADY = 1'b0;
        issue(1'b1, 8'h55, 8'h66);
        step;
        check("ar_pen_before", PENABLE, 1);
        #2;
        PRESET = 1'b1;
        #1;
        check("ar_psel", PSEL, 0);
        check("ar_pen", PENABLE, 0);
        check("ar_valid", rsp_valid, 0);
        check("ar_ready", cmd_ready, 0);
        check("ar_paddr", PADDR, 0);
        PREADY = 1'b1;
        step;
        check("ar_hold_psel", PSEL, 0);
        PRESET = 1'b0;
        step;
        check("ar_rel_ready", cmd_ready, 1);
        check("ar_rel_nrsp", rsp_valid, 0);
        step;
        check("ar_rel_nrsp2", rsp_valid, 0);
        PRDATA = 8'hE1;
        issue(1'b0, 8'h77, 8'h00);
        check("ar_next_paddr", PADDR, 8'h77);
        step;
        step;
        check("ar_next_valid", rsp_valid, 1);
        check("ar_next_rdata", rsp_rdata, 8'hE1);
        check("ar_next_err", rsp_err, 0);
        step;
        check("ar_next_done", cmd_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
